queue_fifo_param: RTL



---
 rtl/queue_pkg.sv | 13 +
 rtl/queue_ram.sv | 29 ++
 rtl/queue_fifo_param.sv | 116 +++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared defaults and helpers for the parametrised circular-buffer queue.
`timescale 1ns/1ps
package queue_pkg;

    localparam int QUEUE_DATA_W_DEF = 8;
    localparam int QUEUE_DEPTH_DEF  = 8;

    // Occupancy counter must reach DEPTH inclusive, hence depth+1 states.
    function automatic int queue_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_ram.sv
// DEPTH x DATA_W storage for the queue: synchronous write, asynchronous read.
`timescale 1ns/1ps
module queue_ram
    import queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W_DEF,
    parameter int DEPTH  = QUEUE_DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/queue_fifo_param.sv
// Parametrised circular-buffer FIFO with sticky error flags and flush.
// Define QUEUE_FWFT_EN for first-word-fall-through output; default is registered output.
`timescale 1ns/1ps
module queue_fifo_param
    import queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W_DEF,
    parameter int DEPTH  = QUEUE_DEPTH_DEF,
    parameter int CNT_W  = queue_cnt_w(DEPTH)
) (
    input  logic              clk_10khz,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic              clear_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [CNT_W-1:0]  len_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              empty_s;
    logic              full_s;
    logic              deq_ok_s;
    logic              enq_ok_s;
    logic              we_s;
    logic [DATA_W-1:0] rd_data_s;

    assign empty_s  = (count_r == CNT_W'(0));
    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign deq_ok_s = dequeue_in & ~empty_s;
    // A full queue can still take a word when the head leaves on the same edge.
    assign enq_ok_s = enqueue_in & (~full_s | deq_ok_s);
    assign we_s     = enq_ok_s & reset_n & ~clear_in;

    queue_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk    (clk_10khz),
        .we     (we_s),
        .waddr  (wr_ptr_r),
        .wdata  (data_in),
        .raddr  (rd_ptr_r),
        .rdata  (rd_data_s)
    );

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk_10khz) begin
        if (!reset_n || clear_in) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (enq_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(enq_ok_s) - CNT_W'(deq_ok_s);
            if (enqueue_in && !enq_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (dequeue_in && !deq_ok_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign len_out       = count_r;
    assign full_out      = full_s;
    assign empty_out     = empty_s;
    assign overflow_out  = overflow_r;
    assign underflow_out = underflow_r;

`ifdef QUEUE_FWFT_EN
    // Head word is shown as long as something is queued; dequeue acknowledges it.
    assign data_out       = empty_s ? {DATA_W{1'b0}} : rd_data_s;
    assign data_valid_out = ~empty_s;
`else
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    // Registered read: the dequeued head appears one cycle after the dequeue edge.
    always_ff @(posedge clk_10khz) begin
        if (!reset_n || clear_in) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= deq_ok_s;
            if (deq_ok_s) begin
                data_r <= rd_data_s;
            end
        end
    end

    assign data_out       = data_r;
    assign data_valid_out = valid_r;
`endif

endmodule
